// File: rtl/img_pkg.sv
// Shared image-pipeline types and sizes for the 3x3 window path.
// PIXEL_WIDTH is the default pixel width; modules take their own DATA_WIDTH parameter.
package img_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int WIN_DIM     = 3;
    localparam int WIN_PIXELS  = 9;

    typedef logic [PIXEL_WIDTH-1:0]            pixel_t;
    typedef logic [WIN_PIXELS*PIXEL_WIDTH-1:0] window_t;

    // Byte slot of window element (row, col), row-major with the oldest row first.
    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/window_generator_3x3_line_buffer.sv
// One image line of storage: combinational read at addr, write at the same addr on the
// clock edge, so a read and a write in one cycle return the old contents.
module line_buffer #(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_generator_3x3.sv
// Raster-stream to 3x3 window generator: two line buffers feed a 3x3 shift window;
// one registered window with a valid strobe per pixel that completes a full window.
module window_generator_3x3
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_pixel_valid,
    input  logic [DATA_WIDTH-1:0]            i_pixel,
    input  logic                             i_sof,
    output logic [WIN_PIXELS*DATA_WIDTH-1:0] o_window,
    output logic                             o_window_valid,
    output logic                             o_frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [COL_W-1:0] col_q, col_d, cur_col_s;
    logic [ROW_W-1:0] row_q, row_d, cur_row_s;
    logic [DATA_WIDTH-1:0] top_s, mid_s;
    logic [DATA_WIDTH-1:0] win_q [WIN_DIM][WIN_DIM];
    logic [DATA_WIDTH-1:0] win_d [WIN_DIM][WIN_DIM];
    logic [WIN_PIXELS*DATA_WIDTH-1:0] window_q, window_d;
    logic valid_q, valid_d;
    logic done_q, done_d;

    // LB_A keeps row r-1, LB_B keeps row r-2; LB_B is refilled from what LB_A held.
    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(COL_W)) u_lb_a (
        .clk(clk), .we(i_pixel_valid), .addr(cur_col_s), .wr_data(i_pixel), .rd_data(mid_s)
    );
    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(COL_W)) u_lb_b (
        .clk(clk), .we(i_pixel_valid), .addr(cur_col_s), .wr_data(mid_s), .rd_data(top_s)
    );

    // Position of the current pixel (sof forces (0,0)), counter advance, window shift and packing.
    always_comb begin
        cur_col_s = i_sof ? '0 : col_q;
        cur_row_s = i_sof ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        window_d  = window_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        if (i_pixel_valid) begin
            if (cur_col_s == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (cur_row_s == ROW_W'(IMG_HEIGHT - 1)) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = cur_row_s + ROW_W'(1);
                end
            end else begin
                col_d = cur_col_s + COL_W'(1);
                row_d = cur_row_s;
            end
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][WIN_DIM-1] = top_s;
            win_d[1][WIN_DIM-1] = mid_s;
            win_d[2][WIN_DIM-1] = i_pixel;
            if ((cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2))) begin
                valid_d = 1'b1;
                for (int r = 0; r < WIN_DIM; r++) begin
                    for (int c = 0; c < WIN_DIM; c++) begin
                        window_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
                    end
                end
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            window_q <= window_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            win_q    <= win_d;
        end
    end

    assign o_window       = window_q;
    assign o_window_valid = valid_q;
    assign o_frame_done   = done_q;

endmodule

// File: tb/tb_window_generator_3x3.sv
// Randomised bench for window_generator_3x3 (5x4 image) against a frame-array reference model.
module tb_window_generator_3x3;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pixel_valid = 1'b0;
    logic [DW-1:0] i_pixel = 8'h00;
    logic          i_sof = 1'b0;
    logic [9*DW-1:0] o_window;
    logic          o_window_valid;
    logic          o_frame_done;

    window_generator_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel), .i_sof(i_sof),
        .o_window(o_window), .o_window_valid(o_window_valid), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remembers every pixel by its (row, col) in the frame.
    logic [DW-1:0]   img_m [0:H-1][0:W-1];
    int              m_row = 0;
    int              m_col = 0;
    logic            exp_valid = 1'b0;
    logic            exp_done  = 1'b0;
    logic [9*DW-1:0] exp_win   = '0;

    int              win_cnt, done_cnt;
    logic            first_seen;
    logic [9*DW-1:0] first_win, last_win;

    task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic clear_stats();
        win_cnt = 0; done_cnt = 0; first_seen = 1'b0; first_win = '0; last_win = '0;
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] p, input logic s);
        int r, c;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img_m[r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_valid = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[(i*3+j)*DW +: DW] = img_m[r-2+i][c-2+j];
            end
            exp_done = (r == H-1) && (c == W-1);
            c++;
            if (c == W) begin
                c = 0;
                r = (r == H-1) ? 0 : r + 1;
            end
            m_row = r;
            m_col = c;
        end
    endtask

    // One clock cycle: apply inputs, advance the model, compare just after the edge.
    task automatic drive(input logic v, input logic [DW-1:0] p, input logic s);
        i_pixel_valid = v;
        i_pixel       = p;
        i_sof         = s;
        model_step(v, p, s);
        @(posedge clk);
        #1;
        check("valid", {71'd0, o_window_valid}, {71'd0, exp_valid});
        check("frame_done", {71'd0, o_frame_done}, {71'd0, exp_done});
        check("window", o_window, exp_win);
        if (o_window_valid) begin
            win_cnt++;
            last_win = o_window;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_win  = o_window;
            end
        end
        if (o_frame_done) done_cnt++;
    endtask

    // Accepts one pixel, optionally preceded by random idle cycles (with random sof noise).
    task automatic feed(input logic [DW-1:0] p, input logic s, input bit gaps);
        if (gaps) begin
            int n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) drive(1'b0, 8'($urandom), 1'($urandom));
        end
        drive(1'b1, p, s);
    endtask

    task automatic nibble_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                feed({r[3:0], c[3:0]}, (r == 0 && c == 0), gaps);
    endtask

    localparam logic [9*DW-1:0] FIRST_NIB_WIN = 72'h22_21_20_12_11_10_02_01_00;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_window", o_window, '0);
        check("rst_valid", {71'd0, o_window_valid}, 72'd0);
        check("rst_done", {71'd0, o_frame_done}, 72'd0);
        rst = 1'b1;

        // Continuous nibble frame
        clear_stats();
        nibble_frame(1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check("s1_win_cnt", 72'(win_cnt), 72'd6);
        check("s1_first_win", first_win, FIRST_NIB_WIN);
        check("s1_last_byte8", {64'd0, last_win[71:64]}, 72'h34);
        check("s1_done_cnt", 72'(done_cnt), 72'd1);

        // Same frame with random valid gaps
        clear_stats();
        nibble_frame(1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check("s2_win_cnt", 72'(win_cnt), 72'd6);
        check("s2_first_win", first_win, FIRST_NIB_WIN);
        check("s2_last_byte8", {64'd0, last_win[71:64]}, 72'h34);

        // Two back-to-back random frames, sof only on the first
        clear_stats();
        for (int k = 0; k < 2*W*H; k++) feed(8'($urandom), (k == 0), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("s3_win_cnt", 72'(win_cnt), 72'd12);
        check("s3_done_cnt", 72'(done_cnt), 72'd2);

        // Reset mid-row 2, then a fresh frame
        for (int k = 0; k < 2*W + 4; k++) feed(8'($urandom), (k == 0), 1'b0);
        i_pixel_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_window", o_window, '0);
        check("mid_rst_valid", {71'd0, o_window_valid}, 72'd0);
        m_row = 0; m_col = 0; exp_win = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_stats();
        nibble_frame(1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check("s4_win_cnt", 72'(win_cnt), 72'd6);
        check("s4_first_win", first_win, FIRST_NIB_WIN);

        // sof at old (1,3): window follows the 13th pixel from there
        for (int k = 0; k < W + 3; k++) feed(8'($urandom), (k == 0), 1'b0);
        clear_stats();
        for (int k = 0; k < 12; k++) feed(8'($urandom), (k == 0), 1'b0);
        check("s5_before_13", 72'(win_cnt), 72'd0);
        feed(8'($urandom), 1'b0, 1'b0);
        check("s5_after_13", 72'(win_cnt), 72'd1);
        for (int k = 0; k < 8; k++) feed(8'($urandom), 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
